// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned VGA_H_DISP = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_DISP = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  function automatic int unsigned calc_total(input int unsigned disp, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return disp + fp + sync + bp;
  endfunction

  // True when a counter of width w can hold every value 0..total-1.
  function automatic bit width_ok(input int unsigned total, input int unsigned w);
    return $clog2(total) <= w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus visible/sync decode of its next value.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISP = VGA_H_DISP,
  parameter int unsigned FP   = VGA_H_FP,
  parameter int unsigned SYNC = VGA_H_SYNC,
  parameter int unsigned BP   = VGA_H_BP,
  parameter bit          POL  = 1'b0,
  parameter int unsigned W    = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_i,
  output logic [W-1:0] count_c_o,
  output logic         wrap_c_o,
  output logic         active_c_o,
  output logic         sync_active_c_o,
  output logic         sync_lvl_c_o
);

  localparam int unsigned TOTAL   = calc_total(DISP, FP, SYNC, BP);
  localparam int unsigned SYNC_LO = DISP + FP;
  localparam int unsigned SYNC_HI = DISP + FP + SYNC - 1;

  logic [W-1:0] count_q, count_d;

  // wrap_c_o flags the terminal count; the caller qualifies it with its own step.
  assign wrap_c_o = (count_q == W'(TOTAL - 1));

  always_comb begin
    count_d = count_q;
    if (step_i) begin
      count_d = wrap_c_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Decode is done on the post-step value so registered outputs line up with the counter.
  assign count_c_o       = count_d;
  assign active_c_o      = (count_d < W'(DISP));
  assign sync_active_c_o = (count_d >= W'(SYNC_LO)) && (count_d <= W'(SYNC_HI));
  assign sync_lvl_c_o    = sync_active_c_o ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/display-enable generator with pixel-clock divider and aligned outputs.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISP  = VGA_H_DISP,
  parameter int unsigned H_FP    = VGA_H_FP,
  parameter int unsigned H_SYNC  = VGA_H_SYNC,
  parameter int unsigned H_BP    = VGA_H_BP,
  parameter int unsigned V_DISP  = VGA_V_DISP,
  parameter int unsigned V_FP    = VGA_V_FP,
  parameter int unsigned V_SYNC  = VGA_V_SYNC,
  parameter int unsigned V_BP    = VGA_V_BP,
  parameter int unsigned CLK_DIV = 2,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned CNT_W   = 10
) (
  input  logic             CLOCK_50,
  input  logic [3:0]       KEY,
  input  logic             en,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,output logic [15:0]     frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = calc_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (!width_ok(H_TOTAL, CNT_W) || !width_ok(V_TOTAL, CNT_W) ||
      (CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_params
    $error("vga_timing_gen: illegal parameters (CNT_W too small or CLK_DIV outside 1..16)");
  end

  logic clk, rst_n, unused_key;
  assign clk        = CLOCK_50;
  assign rst_n      = KEY[0];
  assign unused_key = ^KEY[3:1];

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_c, div_last_c;

  assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign tick_c     = en && div_last_c;

  // Divider freezes with en low so the pixel phase is preserved across a pause.
  always_comb begin
    div_d = div_q;
    if (en) div_d = div_last_c ? '0 : div_q + DIV_W'(1);
  end

  logic [CNT_W-1:0] h_nxt_c, v_nxt_c;
  logic             h_wrap_c, v_wrap_c, h_act_c, v_act_c;
  logic             h_sync_c, v_sync_c, hs_lvl_c, vs_lvl_c, v_step_c;

  assign v_step_c = tick_c && h_wrap_c;

  vga_axis_counter #(
    .DISP(H_DISP), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(CNT_W)
  ) u_h_axis (
    .clk             (clk),
    .rst_n           (rst_n),
    .step_i          (tick_c),
    .count_c_o       (h_nxt_c),
    .wrap_c_o        (h_wrap_c),
    .active_c_o      (h_act_c),
    .sync_active_c_o (h_sync_c),
    .sync_lvl_c_o    (hs_lvl_c)
  );

  vga_axis_counter #(
    .DISP(V_DISP), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(CNT_W)
  ) u_v_axis (
    .clk             (clk),
    .rst_n           (rst_n),
    .step_i          (v_step_c),
    .count_c_o       (v_nxt_c),
    .wrap_c_o        (v_wrap_c),
    .active_c_o      (v_act_c),
    .sync_active_c_o (v_sync_c),
    .sync_lvl_c_o    (vs_lvl_c)
  );

  logic [CNT_W-1:0] px_q, px_d, py_q, py_d;
  logic             hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic             ptick_q, ptick_d, ls_q, ls_d, fs_q, fs_d;

  // Output stage loads from the post-tick counter values, so every output changes together.
  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    von_d   = von_q;
    ptick_d = tick_c;
    ls_d    = tick_c && h_wrap_c;
    fs_d    = tick_c && h_wrap_c && v_wrap_c;
    if (tick_c) begin
      px_d  = h_nxt_c;
      py_d  = v_nxt_c;
      hs_d  = hs_lvl_c;
      vs_d  = vs_lvl_c;
      von_d = h_act_c && v_act_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      von_q   <= 1'b0;
      ptick_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      px_q    <= px_d;
      py_q    <= py_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      von_q   <= von_d;
      ptick_q <= ptick_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign video_on    = von_q;
  assign p_tick      = ptick_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Steps on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_comb begin
    fcnt_d = fcnt_q;
    if (fs_d) fcnt_d = fcnt_q + 16'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen using a reduced raster so many frames fit.
module tb_vga_timing_gen;

  localparam int unsigned H_DISP = 16, H_FP = 4, H_SYNC = 6, H_BP = 4;
  localparam int unsigned V_DISP = 8,  V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int unsigned CLK_DIV = 3;
  localparam bit          HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hs;
    logic             vs;
    logic             von;
    logic             ls;
    logic             fs;
    logic [15:0]      fc;
  } obs_t;

  logic             clk = 1'b0;
  logic [3:0]       key;
  logic             en;
  logic             vga_hs, vga_vs, video_on, p_tick, line_start, frame_start;
  logic [CNT_W-1:0] pixel_x, pixel_y;
  logic [15:0]      fc_obs;

  always #10 clk = ~clk;

  vga_timing_gen #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50    (clk),
    .KEY         (key),
    .en          (en),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .video_on    (video_on),
    .p_tick      (p_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,.frame_cnt  (fc_obs)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc_obs = 16'h0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_frames = 0;

  function automatic obs_t reset_obs();
    obs_t o;
    o     = '0;
    o.hs  = ~HS_POL;
    o.vs  = ~VS_POL;
    return o;
  endfunction

  // The t-th pixel since reset is simply t mod line length / lines mod frame length.
  function automatic obs_t pixel_obs(input int unsigned t);
    obs_t        o;
    int unsigned x, y;
    x     = t % H_TOT;
    y     = (t / H_TOT) % V_TOT;
    o.x   = CNT_W'(x);
    o.y   = CNT_W'(y);
    o.von = (x < H_DISP) && (y < V_DISP);
    o.hs  = ((x >= H_DISP + H_FP) && (x < H_DISP + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    o.vs  = ((y >= V_DISP + V_FP) && (y < V_DISP + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
    o.ls  = (x == 0);
    o.fs  = (x == 0) && (y == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc  = 16'((t / (H_TOT * V_TOT)) % 65536);
`else
    o.fc  = 16'h0;
`endif
    return o;
  endfunction

  // Reference model: count enabled cycles since reset; every CLK_DIV-th is a pixel.
  int unsigned e_cnt = 0, t_cnt = 0;
  obs_t        cur;
  obs_t        exp_q[$];
  logic        exp_ptick = 1'b0;

  always @(posedge clk or negedge key[0]) begin
    if (!key[0]) begin
      e_cnt     = 0;
      t_cnt     = 0;
      cur       = reset_obs();
      exp_ptick = 1'b0;
      exp_q.delete();
    end else begin
      exp_ptick = 1'b0;
      if (en) begin
        e_cnt++;
        if (e_cnt % CLK_DIV == 0) begin
          t_cnt++;
          cur = pixel_obs(t_cnt);
          exp_q.push_back(cur);
          exp_ptick = 1'b1;
        end
      end
    end
  end

  // Monitor: pops on each p_tick, otherwise checks that outputs hold with strobes low.
  always @(negedge clk) begin
    obs_t act, exp;
    act = '{x: pixel_x, y: pixel_y, hs: vga_hs, vs: vga_vs, von: video_on,
            ls: line_start, fs: frame_start, fc: fc_obs};
    n_checks++;
    if (p_tick !== exp_ptick) begin
      n_errors++;
      $display("FAIL p_tick @%0t: got %b expected %b", $time, p_tick, exp_ptick);
    end
    if (p_tick === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pixel_update @%0t: p_tick with no expected pixel, got %h", $time, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL pixel_update @%0t: got %h expected %h", $time, act, exp);
        end
        if (frame_start === 1'b1) n_frames++;
      end
    end else begin
      exp    = cur;
      exp.ls = 1'b0;
      exp.fs = 1'b0;
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL hold @%0t: got %h expected %h", $time, act, exp);
      end
    end
  end

  task automatic step(input logic en_v);
    @(posedge clk);
    #3;
    en = en_v;
  endtask

  initial begin
    key = 4'b1010;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    key[0] = 1'b1;
    en     = 1'b1;
    // Three full frames at full enable.
    repeat (3 * H_TOT * V_TOT * CLK_DIV + 20) step(1'b1);
    // A long pause followed by resume.
    repeat (37) step(1'b0);
    repeat (200) step(1'b1);
    repeat (6000) step($urandom_range(0, 3) != 0);
    // Random enable with occasional asynchronous reset pulses.
    for (int i = 0; i < 12000; i++) begin
      step($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1499) == 0) begin
        key[0] = 1'b0;
        repeat ($urandom_range(1, 3)) step($urandom_range(0, 1) != 0);
        key[0] = 1'b1;
      end
    end
    // Mid-frame reset followed by a full frame.
    key[0] = 1'b0;
    step(1'b1);
    key[0] = 1'b1;
    repeat (H_TOT * V_TOT * CLK_DIV + 10) step(1'b1);
    repeat (4) step(1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending pixels expected 0", exp_q.size());
    end
    n_checks++;
    if (n_frames < 4) begin
      n_errors++;
      $display("FAIL frame_seen: got %0d frame_start strobes expected at least 4", n_frames);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
